// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of a single SDRAM controller port, one transaction outstanding.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on ties instead of fixed port-1 priority.
module sdram_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_rvalid,
    input  logic              req1_valid,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_in_valid,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_out_valid,
    output logic              timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, WAIT_WR, WAIT_RD} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              req0_ready_q, req0_ready_d;
    logic              req1_ready_q, req1_ready_d;
    logic              req0_rvalid_q, req0_rvalid_d;
    logic              req1_rvalid_q, req1_rvalid_d;
    logic [DATA_W-1:0] req0_rdata_q, req0_rdata_d;
    logic [DATA_W-1:0] req1_rdata_q, req1_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rw_q, mem_rw_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_in_valid_q, mem_in_valid_d;
    logic              timeout_err_q, timeout_err_d;
    logic              grant;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_grant_q, last_grant_d;
`endif

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        wd_d           = wd_q;
        req0_ready_d   = 1'b0;
        req1_ready_d   = 1'b0;
        req0_rvalid_d  = 1'b0;
        req1_rvalid_d  = 1'b0;
        req0_rdata_d   = req0_rdata_q;
        req1_rdata_d   = req1_rdata_q;
        mem_addr_d     = mem_addr_q;
        mem_rw_d       = mem_rw_q;
        mem_wdata_d    = mem_wdata_q;
        mem_in_valid_d = 1'b0;
        timeout_err_d  = timeout_err_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d   = last_grant_q;
        grant          = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
`else
        grant          = req1_valid;
`endif

        case (state_q)
            IDLE: begin
                if ((req0_valid || req1_valid) && !mem_busy) begin
                    owner_d        = grant;
                    mem_in_valid_d = 1'b1;
                    wd_d           = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d   = grant;
`endif
                    if (grant) begin
                        req1_ready_d = 1'b1;
                        mem_addr_d   = req1_addr;
                        mem_rw_d     = req1_rw;
                        mem_wdata_d  = req1_wdata;
                        state_d      = req1_rw ? SETTLE : WAIT_RD;
                    end else begin
                        req0_ready_d = 1'b1;
                        mem_addr_d   = req0_addr;
                        mem_rw_d     = req0_rw;
                        mem_wdata_d  = req0_wdata;
                        state_d      = req0_rw ? SETTLE : WAIT_RD;
                    end
                end
            end
            SETTLE:  state_d = WAIT_WR;
            WAIT_WR: if (!mem_busy) state_d = IDLE;
            WAIT_RD: begin
                wd_d = wd_q + WD_W'(1);
                // returned data takes precedence over a watchdog expiry in the same cycle
                if (mem_out_valid || wd_d == WD_W'(TIMEOUT)) begin
                    state_d = IDLE;
                    if (!mem_out_valid) timeout_err_d = 1'b1;
                    if (owner_q) begin
                        req1_rvalid_d = 1'b1;
                        req1_rdata_d  = mem_out_valid ? mem_rdata : '0;
                    end else begin
                        req0_rvalid_d = 1'b1;
                        req0_rdata_d  = mem_out_valid ? mem_rdata : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            wd_q           <= '0;
            req0_ready_q   <= 1'b0;
            req1_ready_q   <= 1'b0;
            req0_rvalid_q  <= 1'b0;
            req1_rvalid_q  <= 1'b0;
            req0_rdata_q   <= '0;
            req1_rdata_q   <= '0;
            mem_addr_q     <= '0;
            mem_rw_q       <= 1'b0;
            mem_wdata_q    <= '0;
            mem_in_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q   <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            wd_q           <= wd_d;
            req0_ready_q   <= req0_ready_d;
            req1_ready_q   <= req1_ready_d;
            req0_rvalid_q  <= req0_rvalid_d;
            req1_rvalid_q  <= req1_rvalid_d;
            req0_rdata_q   <= req0_rdata_d;
            req1_rdata_q   <= req1_rdata_d;
            mem_addr_q     <= mem_addr_d;
            mem_rw_q       <= mem_rw_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_in_valid_q <= mem_in_valid_d;
            timeout_err_q  <= timeout_err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q   <= last_grant_d;
`endif
        end
    end

    assign req0_ready   = req0_ready_q;
    assign req1_ready   = req1_ready_q;
    assign req0_rvalid  = req0_rvalid_q;
    assign req1_rvalid  = req1_rvalid_q;
    assign req0_rdata   = req0_rdata_q;
    assign req1_rdata   = req1_rdata_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rw       = mem_rw_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_in_valid = mem_in_valid_q;
    assign timeout_err  = timeout_err_q;
endmodule
